psk4_demodulator: RTL and testbench
===================================

# psk4_demodulator

Coherent 4-phase PSK demodulator: the receive-side counterpart of the team's 4-PSK modulator. It takes 8-bit offset-binary sine samples, 32 samples per symbol, and correlates each symbol window against square-wave sine and cosine references. From the signs and magnitudes of the two correlations it recovers the Gray-coded 2-bit symbol (phase offsets 0/8/16/24 of 32 map to 00/01/11/10). It sits between the sample source (loopback or ADC path) and the bit sink, and emits each symbol both in parallel and as a 2-bit serial burst.

## Interface
- MID, 128: sample midpoint subtracted before correlation
- SPS, 32: samples per symbol; must be a power of two ≥ 8
- ACC_W, 14: signed accumulator width
- THRESH, 512: minimum max(|I|,|Q|) for a valid symbol (used only with the energy check)

- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- sample_valid  in  1  sample strobe; may be gapped arbitrarily
- sample  in  8  offset-binary waveform sample
- sync  in  1  marks the first sample of a symbol; honoured only when sample_valid=1
- sym_out  out  2  decided symbol, first-arrived bit in MSB
- sym_valid  out  1  one-cycle pulse, sym_out updated
- bit_out  out  1  serial bit, MSB first
- bit_valid  out  1  high for 2 consecutive cycles per symbol
- locked  out  1  high while in RUN
- sym_err  out  1  one-cycle pulse, low-energy symbol (only with the energy check)

## Operation
- States: IDLE (after reset; no accumulation) and RUN. IDLE→RUN on sync&sample_valid. RUN stays in RUN; only rst returns the block to IDLE.
- Sample index idx (log2(SPS) bits) advances only on accepted samples (sample_valid=1 in RUN, or the sync sample itself). It wraps SPS-1→0 and free-runs between syncs.
- sync&sample_valid in RUN forces idx=0 for that sample and discards the partial window. No symbol is emitted for the discarded window.
- d = sample − MID, signed 9-bit.
- Sine reference: +1 for idx<SPS/2, else −1.
- Cosine reference: +1 for idx<SPS/4 or idx≥3SPS/4, else −1.
- At idx=0 the accumulators load: I=±d, Q=±d. Otherwise I+=±d, Q+=±d. Arithmetic is signed two's complement ACC_W bits, with no saturation required (worst case 32·128 fits in 14 bits).
- Decision is made on the window's final I,Q:
  - |I|≥|Q|: I≥0 → 00, else → 11.
  - |I|<|Q|: Q>0 → 01, else → 10.
  - Tie |I|==|Q| resolves to the I axis.
- Serial output: bit_out=sym_out[1] with bit_valid in the first cycle, then sym_out[0] in the next cycle.

## Timing
- Reset values: sym_out=00, sym_valid=0, bit_out=0, bit_valid=0, locked=0, sym_err=0. Accumulators and idx are cleared; state is IDLE.
- Last sample (idx=SPS−1) accepted at edge T:
  - at T+1 the final I,Q are registered;
  - at T+2 sym_out, sym_valid, the MSB bit_out and bit_valid are registered;
  - at T+3 the LSB bit_out is registered with bit_valid=1;
  - at T+4 bit_valid=0.
- Latency from last sample to sym_valid: 2 cycles.
- Samples of the next window may be accepted during T+1..T+3 without disturbing the pending decision. The final I,Q are held separately from the running accumulators.
- sym_out holds its value until the next decision.
- rst asserted mid-window or mid-serial-burst: outputs go to reset values immediately and the in-flight symbol is dropped.
- locked rises the cycle after the first sync is accepted.

## Configuration
- PSK4_DEMOD_ENERGY_CHECK_EN defined:
  - if max(|I|,|Q|)<THRESH, the block pulses sym_err at T+2 instead of sym_valid;
  - no serial burst is produced and sym_out is unchanged.
- Not defined: every completed window produces a symbol; sym_err is tied 0 and THRESH is unused.

## Test plan
- Reset, then sync on the first of 32 samples of 128+round(127·sin(2π(n+b)/32)) for b=0,8,16,24 back-to-back → sym_out 00,01,11,10 in order. Each sym_valid comes 2 cycles after the 32nd sample; bit_out sequences are 0,0 / 0,1 / 1,1 / 1,0.
- The same stream with sample_valid at a 1-in-16 duty → identical symbols, each sym_valid 2 clk after that window's last valid sample.
- sync re-asserted at idx=13 of a b=8 window, then a full b=16 window → no symbol for the truncated window, then exactly one symbol 11.
- Constant sample=128 for 32 samples:
  - with PSK4_DEMOD_ENERGY_CHECK_EN: sym_err pulse, no sym_valid, sym_out unchanged;
  - without it: sym_out=00 via the tie rule.
- rst asserted at idx=20 of a window → all outputs 0 and locked=0 next edge. A subsequent b=24 window with sync → sym_out=10.
- Samples before any sync → no sym_valid and locked stays 0.

Source files
------------

// File: rtl/psk4_demodulator.sv
// Coherent 4-PSK demodulator: square-wave I/Q correlation over SPS-sample windows, Gray decision, 2-bit serial burst.
// Optional low-energy rejection is enabled by defining PSK4_DEMOD_ENERGY_CHECK_EN.
module psk4_demodulator #(
  parameter int MID    = 128,
  parameter int SPS    = 32,
  parameter int ACC_W  = 14,
  parameter int THRESH = 512
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sample_valid_i,
  input  logic [7:0] sample_i,
  input  logic       sync_i,
  output logic [1:0] sym_out_o,
  output logic       sym_valid_o,
  output logic       bit_out_o,
  output logic       bit_valid_o,
  output logic       locked_o,
  output logic       sym_err_o
);
  localparam int IW     = $clog2(SPS);
  localparam int STAGES = 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [IW-1:0] IDX_Q1   = IW'(SPS / 4);
  localparam logic [IW-1:0] IDX_HALF = IW'(SPS / 2);
  localparam logic [IW-1:0] IDX_Q3   = IW'(3 * SPS / 4);
  localparam logic [IW-1:0] IDX_LAST = IW'(SPS - 1);

  logic [0:0]              state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d, idx_use;
  logic                    accept, win_last;
  logic signed [8:0]       d9;
  logic signed [ACC_W-1:0] dx;
  logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [ACC_W-1:0] fin_i_q, fin_q_q;
  logic [STAGES:0]         vld_pipe;
  logic [ACC_W-1:0]        abs_i, abs_q, mag;
  logic [1:0]              dec;
  logic                    sym_ok;
  logic [1:0]              sym_q;
  logic                    sym_valid_q, bit_q, bit_valid_q, lsb_pend_q, sym_err_q;

  // Front end: a sync sample restarts the window at idx 0, dropping any partial sums.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE && sample_valid_i && sync_i) state_d = ST_RUN;
    accept   = sample_valid_i && (state_q == ST_RUN || sync_i);
    idx_use  = sync_i ? '0 : idx_q;
    idx_d    = idx_use + IW'(1);
    win_last = accept && (idx_use == IDX_LAST);
    d9       = $signed({1'b0, sample_i}) - $signed(9'(MID));
    dx       = {{(ACC_W-9){d9[8]}}, d9};
    acc_i_d  = (idx_use == '0) ? '0 : acc_i_q;
    acc_q_d  = (idx_use == '0) ? '0 : acc_q_q;
    acc_i_d  = (idx_use < IDX_HALF) ? acc_i_d + dx : acc_i_d - dx;
    acc_q_d  = (idx_use < IDX_Q1 || idx_use >= IDX_Q3) ? acc_q_d + dx : acc_q_d - dx;
  end

  // Decision on the held window totals; ties go to the I axis.
  always_comb begin
    abs_i = fin_i_q[ACC_W-1] ? -fin_i_q : fin_i_q;
    abs_q = fin_q_q[ACC_W-1] ? -fin_q_q : fin_q_q;
    if (abs_i >= abs_q) begin
      dec = fin_i_q[ACC_W-1] ? 2'b11 : 2'b00;
      mag = abs_i;
    end else begin
      dec = (!fin_q_q[ACC_W-1] && fin_q_q != '0) ? 2'b01 : 2'b10;
      mag = abs_q;
    end
  end

`ifdef PSK4_DEMOD_ENERGY_CHECK_EN
  assign sym_ok = (mag >= ACC_W'(THRESH));
`else
  logic unused_low;
  assign unused_low = (mag < ACC_W'(THRESH));
  assign sym_ok     = 1'b1;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      fin_i_q     <= '0;
      fin_q_q     <= '0;
      vld_pipe    <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      lsb_pend_q  <= 1'b0;
      sym_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q   <= idx_d;
        acc_i_q <= acc_i_d;
        acc_q_q <= acc_q_d;
      end
      vld_pipe <= {vld_pipe[STAGES-1:0], win_last};
      // Snapshot lets the next window start accumulating immediately.
      if (vld_pipe[0]) begin
        fin_i_q <= acc_i_q;
        fin_q_q <= acc_q_q;
      end
      sym_valid_q <= vld_pipe[STAGES] && sym_ok;
      sym_err_q   <= vld_pipe[STAGES] && !sym_ok;
      if (vld_pipe[STAGES] && sym_ok) begin
        sym_q       <= dec;
        bit_q       <= dec[1];
        bit_valid_q <= 1'b1;
        lsb_pend_q  <= 1'b1;
      end else if (lsb_pend_q) begin
        bit_q       <= sym_q[0];
        bit_valid_q <= 1'b1;
        lsb_pend_q  <= 1'b0;
      end else begin
        bit_valid_q <= 1'b0;
      end
    end
  end

  assign sym_out_o   = sym_q;
  assign sym_valid_o = sym_valid_q;
  assign bit_out_o   = bit_q;
  assign bit_valid_o = bit_valid_q;
  assign locked_o    = state_q;
  assign sym_err_o   = sym_err_q;

endmodule

// File: tb/tb_psk4_demodulator.sv
// Directed bench for psk4_demodulator: phase windows, gapped samples, resync, zero energy, mid-window reset.
module tb_psk4_demodulator;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_valid = 1'b0;
  logic [7:0] sample = 8'd0;
  logic       sync = 1'b0;
  logic [1:0] sym_out;
  logic       sym_valid, bit_out, bit_valid, locked, sym_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_cyc = 0;

  logic [1:0] vq_sym[$];
  int         vq_cyc[$];
  logic       bq_bit[$];
  int         bq_cyc[$];
  int         eq_cyc[$];

  int         B[4]   = '{0, 8, 16, 24};
  logic [1:0] EXP[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  psk4_demodulator dut (
    .clk_i(clk), .rst_i(rst), .sample_valid_i(sample_valid), .sample_i(sample), .sync_i(sync),
    .sym_out_o(sym_out), .sym_valid_o(sym_valid), .bit_out_o(bit_out), .bit_valid_o(bit_valid),
    .locked_o(locked), .sym_err_o(sym_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled on the falling edge, away from register updates.
  always @(negedge clk) begin
    if (sym_valid) begin vq_sym.push_back(sym_out); vq_cyc.push_back(cyc); end
    if (bit_valid) begin bq_bit.push_back(bit_out); bq_cyc.push_back(cyc); end
    if (sym_err) eq_cyc.push_back(cyc);
  end

  function automatic logic [7:0] wav(input int n, input int b);
    real x;
    x = 127.0 * $sin(2.0 * 3.14159265358979 * real'(n + b) / 32.0);
    return 8'(128 + $rtoi(x >= 0.0 ? x + 0.5 : x - 0.5));
  endfunction

  task automatic clr();
    vq_sym.delete(); vq_cyc.delete(); bq_bit.delete(); bq_cyc.delete(); eq_cyc.delete();
  endtask

  task automatic drv(input logic v, input logic [7:0] s, input logic sy);
    @(negedge clk);
    sample_valid = v; sample = s; sync = sy;
    if (v) last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 8'd0, 1'b0);
  endtask

  task automatic send_window(input int b, input bit with_sync, input int gap, input int n0,
                             input int nsamp, output int lc);
    for (int n = n0; n < nsamp; n++) begin
      for (int g = 0; g < gap; g++) drv(1'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      drv(1'b1, wav(n, b), 1'(with_sync && n == 0));
    end
    lc = last_cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (sym_out !== 2'b00) begin errors++; $display("FAIL reset_sym_out: got %0d want 0", sym_out); end
    checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL reset_sym_valid: got %0d want 0", sym_valid); end
    checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL reset_bit_out: got %0d want 0", bit_out); end
    checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL reset_bit_valid: got %0d want 0", bit_valid); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0d want 0", locked); end
    checks++; if (sym_err !== 1'b0) begin errors++; $display("FAIL reset_sym_err: got %0d want 0", sym_err); end
  endtask

  task automatic test_no_sync();
    int lc;
    clr();
    send_window(0, 1'b0, 0, 0, 40, lc);
    idle(6);
    checks++; if (vq_sym.size() != 0) begin errors++; $display("FAIL nosync_syms: got %0d want 0", vq_sym.size()); end
    checks++; if (bq_bit.size() != 0) begin errors++; $display("FAIL nosync_bits: got %0d want 0", bq_bit.size()); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL nosync_locked: got %0d want 0", locked); end
  endtask

  task automatic test_back_to_back();
    int lcs[4];
    clr();
    drv(1'b1, wav(0, 0), 1'b1);
    @(posedge clk); #1;
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL b2b_locked_rise: got %0d want 1", locked); end
    send_window(0, 1'b0, 0, 1, 32, lcs[0]);
    for (int w = 1; w < 4; w++) send_window(B[w], 1'b0, 0, 0, 32, lcs[w]);
    idle(6);
    checks++;
    if (vq_sym.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", vq_sym.size()); end
    else for (int w = 0; w < 4; w++) begin
      checks++; if (vq_sym[w] !== EXP[w]) begin errors++; $display("FAIL b2b_sym%0d: got %0d want %0d", w, vq_sym[w], EXP[w]); end
      checks++; if (vq_cyc[w] != lcs[w] + 3) begin errors++; $display("FAIL b2b_lat%0d: got %0d want %0d", w, vq_cyc[w], lcs[w] + 3); end
    end
    checks++;
    if (bq_bit.size() != 8) begin errors++; $display("FAIL b2b_nbits: got %0d want 8", bq_bit.size()); end
    else for (int w = 0; w < 4; w++) begin
      checks++; if (bq_bit[2*w] !== EXP[w][1] || bq_cyc[2*w] != lcs[w] + 3) begin
        errors++; $display("FAIL b2b_msb%0d: got %0d@%0d want %0d@%0d", w, bq_bit[2*w], bq_cyc[2*w], EXP[w][1], lcs[w] + 3); end
      checks++; if (bq_bit[2*w+1] !== EXP[w][0] || bq_cyc[2*w+1] != lcs[w] + 4) begin
        errors++; $display("FAIL b2b_lsb%0d: got %0d@%0d want %0d@%0d", w, bq_bit[2*w+1], bq_cyc[2*w+1], EXP[w][0], lcs[w] + 4); end
    end
  endtask

  task automatic test_gapped();
    int lcs[4];
    clr();
    for (int w = 0; w < 4; w++) send_window(B[w], w == 0, 15, 0, 32, lcs[w]);
    idle(6);
    checks++;
    if (vq_sym.size() != 4) begin errors++; $display("FAIL gap_count: got %0d want 4", vq_sym.size()); end
    else for (int w = 0; w < 4; w++) begin
      checks++; if (vq_sym[w] !== EXP[w]) begin errors++; $display("FAIL gap_sym%0d: got %0d want %0d", w, vq_sym[w], EXP[w]); end
      checks++; if (vq_cyc[w] != lcs[w] + 3) begin errors++; $display("FAIL gap_lat%0d: got %0d want %0d", w, vq_cyc[w], lcs[w] + 3); end
    end
    checks++; if (bq_bit.size() != 8) begin errors++; $display("FAIL gap_nbits: got %0d want 8", bq_bit.size()); end
  endtask

  task automatic test_resync();
    int lc;
    clr();
    send_window(8, 1'b1, 0, 0, 13, lc);
    send_window(16, 1'b1, 0, 0, 32, lc);
    idle(6);
    checks++;
    if (vq_sym.size() != 1) begin errors++; $display("FAIL resync_count: got %0d want 1", vq_sym.size()); end
    else begin
      checks++; if (vq_sym[0] !== 2'b11) begin errors++; $display("FAIL resync_sym: got %0d want 3", vq_sym[0]); end
      checks++; if (vq_cyc[0] != lc + 3) begin errors++; $display("FAIL resync_lat: got %0d want %0d", vq_cyc[0], lc + 3); end
    end
  endtask

  task automatic test_zero();
    int lc;
    clr();
    for (int n = 0; n < 32; n++) drv(1'b1, 8'd128, 1'(n == 0));
    lc = last_cyc;
    idle(6);
`ifdef PSK4_DEMOD_ENERGY_CHECK_EN
    checks++; if (vq_sym.size() != 0) begin errors++; $display("FAIL zero_syms: got %0d want 0", vq_sym.size()); end
    checks++; if (bq_bit.size() != 0) begin errors++; $display("FAIL zero_bits: got %0d want 0", bq_bit.size()); end
    checks++;
    if (eq_cyc.size() != 1) begin errors++; $display("FAIL zero_err_count: got %0d want 1", eq_cyc.size()); end
    else begin
      checks++; if (eq_cyc[0] != lc + 3) begin errors++; $display("FAIL zero_err_lat: got %0d want %0d", eq_cyc[0], lc + 3); end
    end
    checks++; if (sym_out !== 2'b11) begin errors++; $display("FAIL zero_sym_hold: got %0d want 3", sym_out); end
`else
    checks++;
    if (vq_sym.size() != 1) begin errors++; $display("FAIL zero_count: got %0d want 1", vq_sym.size()); end
    else begin
      checks++; if (vq_sym[0] !== 2'b00) begin errors++; $display("FAIL zero_tie_sym: got %0d want 0", vq_sym[0]); end
      checks++; if (vq_cyc[0] != lc + 3) begin errors++; $display("FAIL zero_lat: got %0d want %0d", vq_cyc[0], lc + 3); end
    end
    checks++; if (eq_cyc.size() != 0) begin errors++; $display("FAIL zero_err: got %0d want 0", eq_cyc.size()); end
`endif
  endtask

  task automatic test_rst_mid();
    int lc;
    clr();
    send_window(16, 1'b1, 0, 0, 32, lc);
    send_window(0, 1'b0, 0, 0, 20, lc);
    @(negedge clk);
    sample_valid = 1'b1; sample = wav(20, 0); rst = 1'b1;
    #1;
    checks++; if (sym_out !== 2'b00 || bit_out !== 1'b0) begin errors++; $display("FAIL rstmid_outs: got sym=%0d bit=%0d want 0/0", sym_out, bit_out); end
    checks++; if (sym_valid !== 1'b0 || bit_valid !== 1'b0 || sym_err !== 1'b0) begin errors++; $display("FAIL rstmid_strobes: got %0d%0d%0d want 000", sym_valid, bit_valid, sym_err); end
    @(posedge clk); #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rstmid_locked: got %0d want 0", locked); end
    @(negedge clk);
    rst = 1'b0; sample_valid = 1'b0;
    // Reset landing between the MSB and LSB of a burst.
    clr();
    send_window(24, 1'b1, 0, 0, 32, lc);
    idle(2);
    @(negedge clk);
    checks++; if (bit_valid !== 1'b1 || bit_out !== 1'b1) begin errors++; $display("FAIL burst_msb: got v=%0d b=%0d want 1/1", bit_valid, bit_out); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bit_valid !== 1'b0 || sym_out !== 2'b00) begin errors++; $display("FAIL burst_rst: got v=%0d sym=%0d want 0/0", bit_valid, sym_out); end
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    checks++; if (bq_bit.size() != 1) begin errors++; $display("FAIL burst_drop_lsb: got %0d bits want 1", bq_bit.size()); end
    clr();
    send_window(24, 1'b1, 0, 0, 32, lc);
    idle(6);
    checks++;
    if (vq_sym.size() != 1) begin errors++; $display("FAIL post_rst_count: got %0d want 1", vq_sym.size()); end
    else begin
      checks++; if (vq_sym[0] !== 2'b10) begin errors++; $display("FAIL post_rst_sym: got %0d want 2", vq_sym[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_no_sync();
    test_back_to_back();
    test_gapped();
    test_resync();
    test_zero();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
